// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch (T0-T2), decode/execute (T3-T6), plus PAUSE and HALT.
// All strobes are combinational from the current state and ir; pc_enable also waits on mem_ready.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        stop,
    output logic        pc_out,
    output logic        zlo_out,
    output logic        zhi_out,
    output logic        mdr_out,
    output logic        mar_enable,
    output logic        pc_enable,
    output logic        mdr_enable,
    output logic        ir_enable,
    output logic        y_enable,
    output logic        z_enable,
    output logic        lo_enable,
    output logic        hi_enable,
    output logic        read,
    output logic        pc_increment,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        r_in,
    output logic        r_out,
    output logic [4:0]  op_code,
    output logic        run
);

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_PAUSE, S_HALT
    } state_t;

    state_t state;
    state_t next_state;
    state_t end_state;

    logic [4:0] opc;
    logic       is_binary;
    logic       is_wide;
    logic       is_unary;
    logic       unused_ir_fields;

    assign opc              = ir[31:27];
    assign unused_ir_fields = ^ir[26:0];

    always_comb begin
        is_binary = 1'b0;
        is_wide   = 1'b0;
        is_unary  = 1'b0;
        case (opc)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: is_binary = 1'b1;
            5'b01111, 5'b10000:                     is_wide   = 1'b1;
            5'b10001, 5'b10010:                     is_unary  = 1'b1;
            default: ;
        endcase
    end

    // stop is only looked at on the last step of an instruction
    assign end_state = stop ? S_PAUSE : S_T0;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_T0;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_T0:    next_state = S_T1;
            S_T1:    next_state = mem_ready ? S_T2 : S_T1;
            S_T2:    next_state = S_T3;
            S_T3:    next_state = (is_binary || is_wide || is_unary) ? S_T4 : S_HALT;
            S_T4:    next_state = (is_binary || is_wide) ? S_T5 : end_state;
            S_T5:    next_state = is_wide ? S_T6 : end_state;
            S_T6:    next_state = end_state;
            S_PAUSE: next_state = stop ? S_PAUSE : S_T0;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_HALT;
        endcase
    end

    always_comb begin
        pc_out       = 1'b0;
        zlo_out      = 1'b0;
        zhi_out      = 1'b0;
        mdr_out      = 1'b0;
        mar_enable   = 1'b0;
        pc_enable    = 1'b0;
        mdr_enable   = 1'b0;
        ir_enable    = 1'b0;
        y_enable     = 1'b0;
        z_enable     = 1'b0;
        lo_enable    = 1'b0;
        hi_enable    = 1'b0;
        read         = 1'b0;
        pc_increment = 1'b0;
        gra          = 1'b0;
        grb          = 1'b0;
        grc          = 1'b0;
        r_in         = 1'b0;
        r_out        = 1'b0;
        op_code      = 5'b00000;
        run          = (state != S_PAUSE) && (state != S_HALT);
        case (state)
            S_T0: begin
                pc_out       = 1'b1;
                mar_enable   = 1'b1;
                pc_increment = 1'b1;
                z_enable     = 1'b1;
            end
            S_T1: begin
                zlo_out    = 1'b1;
                read       = 1'b1;
                mdr_enable = 1'b1;
                pc_enable  = mem_ready;
            end
            S_T2: begin
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
            end
            S_T3: begin
                if (is_binary) begin
                    grb      = 1'b1;
                    r_out    = 1'b1;
                    y_enable = 1'b1;
                end else if (is_wide) begin
                    gra      = 1'b1;
                    r_out    = 1'b1;
                    y_enable = 1'b1;
                end else if (is_unary) begin
                    grb      = 1'b1;
                    r_out    = 1'b1;
                    op_code  = opc;
                    z_enable = 1'b1;
                end
            end
            S_T4: begin
                if (is_binary) begin
                    grc      = 1'b1;
                    r_out    = 1'b1;
                    op_code  = opc;
                    z_enable = 1'b1;
                end else if (is_wide) begin
                    grb      = 1'b1;
                    r_out    = 1'b1;
                    op_code  = opc;
                    z_enable = 1'b1;
                end else if (is_unary) begin
                    zlo_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end
            end
            S_T5: begin
                if (is_binary) begin
                    zlo_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end else if (is_wide) begin
                    zlo_out   = 1'b1;
                    lo_enable = 1'b1;
                end
            end
            S_T6: begin
                zhi_out   = 1'b1;
                hi_enable = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The module SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  reset; one clock, synchronous, active-high.
- ir  in  32  datapath IR contents; opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
- mem_ready  in  1  memory read data valid on m_data_in.
- stop  in  1  pause request, honoured only at instruction boundary.
- pc_out, zlo_out, zhi_out, mdr_out  out  1 each  bus drive strobes.
- mar_enable, pc_enable, mdr_enable, ir_enable, y_enable, z_enable, lo_enable, hi_enable  out  1 each  register load strobes.
- read  out  1  MDR selects memory input.
- pc_increment  out  1  ALU computes PC+1.
- gra, grb, grc  out  1 each  select-and-encode field select for Ra, Rb, Rc.
- r_in, r_out  out  1 each  load or drive the register chosen by gra/grb/grc.
- op_code  out  5  ALU operation; 5'b00000 in every state that does not assert z_enable for an execute step.
- run  out  1  high unless the unit is in PAUSE or HALT.

Function
REQ-002 One state per clock; states: T0, T1, T2, T3, T4, T5, T6, PAUSE, HALT; every output is a pure function of state and ir.
REQ-003 Any output not listed for a state SHALL be 0.
REQ-004 T0 SHALL assert pc_out, mar_enable, pc_increment and z_enable, then go to T1.
REQ-005 T1 SHALL assert zlo_out, pc_enable, read and mdr_enable, go to T2 when mem_ready=1, and otherwise stay in T1 with identical outputs.
REQ-006 pc_enable SHALL be asserted only in the T1 cycle where mem_ready=1, so PC loads exactly once per fetch.
REQ-007 T2 SHALL assert mdr_out and ir_enable, then go to T3.
REQ-008 Decoding SHALL use ir in T3 and later; supported opcodes are add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011 (binary); mul 01111, div 10000 (wide); neg 10001, not 10010 (unary).
REQ-009 For a binary opcode the sequence SHALL be:
- T3: grb, r_out, y_enable.
- T4: grc, r_out, op_code=ir[31:27], z_enable.
- T5: zlo_out, gra, r_in.
- End of instruction.
REQ-010 For a wide opcode the sequence SHALL be:
- T3: gra, r_out, y_enable.
- T4: grb, r_out, op_code, z_enable.
- T5: zlo_out, lo_enable.
- T6: zhi_out, hi_enable.
- End of instruction.
REQ-011 For a unary opcode the sequence SHALL be:
- T3: grb, r_out, op_code, z_enable.
- T4: zlo_out, gra, r_in.
- End of instruction.
REQ-012 In T3, any opcode not listed in REQ-008 (including ld, ldi, st, addi, andi, ori and undefined codes) SHALL move the unit to HALT with all strobes 0 in that cycle.
REQ-013 At end of instruction the next state SHALL be PAUSE if stop=1, otherwise T0.
REQ-014 stop asserted mid-instruction SHALL NOT alter the remaining steps.
REQ-015 PAUSE SHALL drive all strobes 0 and run=0, and SHALL go to T0 on the first cycle with stop=0.
REQ-016 HALT SHALL drive all strobes 0 and run=0, and SHALL be left only by clr.
REQ-017 At most one of pc_out, zlo_out, zhi_out, mdr_out, r_out SHALL be high in any cycle.

Reset
REQ-018 clr=1 at a rising edge SHALL force state T0 on the next cycle from any state, including T1 waiting on mem_ready, PAUSE and HALT.
REQ-019 While in the cycle after reset, outputs SHALL be the T0 values, with run=1 and op_code=0.
REQ-020 clr SHALL take priority over mem_ready and stop.

Verification
REQ-021 The bench SHALL cover these directed scenarios, one line each:
- sub: ir=32'h22398000 (sub R4,R7,R3), mem_ready=1 -> T0..T5 in 6 cycles; T4 has grc, r_out, op_code=00100, z_enable; T5 has gra, r_in.
- mul: ir opcode 01111, Ra=R3, Rb=R1 -> T5 lo_enable with zlo_out, T6 hi_enable with zhi_out, then T0; 7 cycles total.
- Memory wait: mem_ready=0 for 3 cycles in T1 -> T1 held 4 cycles, pc_enable high in 1 cycle only.
- Illegal: ir opcode 00000 (ld) -> HALT after T3, run=0, remains after 10 cycles; clr -> T0.
- Pause: stop=1 asserted in T3 of neg -> T4 completes, then PAUSE with run=0; stop=0 -> T0 next cycle.
- Reset mid-op: clr in T4 of add -> T0 next cycle, no r_in pulse emitted.
